// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external ALU between two
// requesters. Each accepted operation is held on the ALU for ALU_LAT cycles,
// its result and flags are captured, and the result is handed back to the
// owning requester over a valid/ready response channel.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1  // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_func,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_res,
  output logic [2:0]  resp0_flags,
  input  logic        resp0_ready,
  // requester 1
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_func,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_res,
  output logic [2:0]  resp1_flags,
  input  logic        resp1_ready,
  // shared ALU
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_func,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_over,
  // status
  output logic        busy,
  output logic        last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic               owner_q;
  logic               last_grant_q;
  logic [3:0]         cnt_q;
  logic [31:0]        op_a_q;
  logic [31:0]        op_b_q;
  logic [3:0]         op_func_q;
  logic [1:0]         resp_valid_q;
  logic [1:0][31:0]   resp_res_q;
  logic [1:0][2:0]    resp_flags_q;

  logic [1:0]         resp_ready;
  logic [1:0]         grant;
  logic               sel_idx;
  logic               sel_any;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [3:0]         sel_func;

  assign resp_ready = {resp1_ready, resp0_ready};

  // Pick the requester to serve: a lone valid wins, a tie alternates away
  // from the last winner. Ready is suppressed while reset is asserted.
  always_comb begin
    sel_any  = req0_valid | req1_valid;
    sel_idx  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    grant    = 2'b00;
    if (!rst && (state_q == IDLE) && sel_any) begin
      grant = sel_idx ? 2'b10 : 2'b01;
    end
    sel_a    = sel_idx ? req1_a    : req0_a;
    sel_b    = sel_idx ? req1_b    : req0_b;
    sel_func = sel_idx ? req1_func : req0_func;
  end

  // Control FSM plus operand, counter and response registers.
  // The counter is loaded with ALU_LAT on accept and the ALU output is
  // captured once it has run down to zero, so the response becomes valid
  // ALU_LAT+1 edges after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_func_q    <= 4'd0;
      resp_valid_q <= 2'b00;
      resp_res_q   <= '0;
      resp_flags_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            op_a_q       <= sel_a;
            op_b_q       <= sel_b;
            op_func_q    <= sel_func;
            owner_q      <= sel_idx;
            last_grant_q <= sel_idx;
            cnt_q        <= 4'(ALU_LAT);
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            resp_res_q[owner_q]   <= alu_res;
            resp_flags_q[owner_q] <= {alu_over, alu_sign, alu_zero};
            resp_valid_q[owner_q] <= 1'b1;
            state_q               <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // only the owner's ready completes the handshake
          if (resp_ready[owner_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_res   = resp_res_q[0];
  assign resp1_res   = resp_res_q[1];
  assign resp0_flags = resp_flags_q[0];
  assign resp1_flags = resp_flags_q[1];
  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign alu_func    = op_func_q;
  assign busy        = (state_q != IDLE);
  assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench. u1 runs with ALU_LAT=1 against a
// combinational ALU, u3 runs with ALU_LAT=3 against an ALU whose output lags
// its operands by two cycles. Both share the requester-side inputs.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_func = 0, req1_func = 0;
  logic        resp0_ready = 1, resp1_ready = 1;

  // u1 outputs
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_res, resp1_res, alu_a, alu_b, alu_res;
  logic [2:0]  resp0_flags, resp1_flags;
  logic [3:0]  alu_func;
  logic        alu_zero, alu_sign, alu_over, busy, last_grant;
  // u3 outputs
  logic        u3_req0_ready, u3_req1_ready, u3_resp0_valid, u3_resp1_valid;
  logic [31:0] u3_resp0_res, u3_resp1_res, u3_alu_a, u3_alu_b, u3_alu_res;
  logic [2:0]  u3_resp0_flags, u3_resp1_flags;
  logic [3:0]  u3_alu_func;
  logic        u3_alu_zero, u3_alu_sign, u3_alu_over, u3_busy, u3_last_grant;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench ALU: func 0 add, func 1 subtract, anything else xor.
  // Returns {over, sign, zero, res}.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
    logic [31:0] r;
    logic        ov;
    case (f)
      4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      default: begin r = a ^ b; ov = 1'b0; end
    endcase
    return {ov, r[31], (r == 32'd0), r};
  endfunction

  assign {alu_over, alu_sign, alu_zero, alu_res} = alu_model(alu_a, alu_b, alu_func);

  logic [34:0] slow_d1 = '0, slow_d2 = '0;
  always @(posedge clk) begin
    slow_d1 <= alu_model(u3_alu_a, u3_alu_b, u3_alu_func);
    slow_d2 <= slow_d1;
  end
  assign {u3_alu_over, u3_alu_sign, u3_alu_zero, u3_alu_res} = slow_d2;

  alu_arbiter #(.ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_res(resp0_res),
    .resp0_flags(resp0_flags), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_res(resp1_res),
    .resp1_flags(resp1_flags), .resp1_ready(resp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_res(alu_res),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_over(alu_over),
    .busy(busy), .last_grant(last_grant)
  );

  alu_arbiter #(.ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req0_ready(u3_req0_ready), .resp0_valid(u3_resp0_valid), .resp0_res(u3_resp0_res),
    .resp0_flags(u3_resp0_flags), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .req1_ready(u3_req1_ready), .resp1_valid(u3_resp1_valid), .resp1_res(u3_resp1_res),
    .resp1_flags(u3_resp1_flags), .resp1_ready(resp1_ready),
    .alu_a(u3_alu_a), .alu_b(u3_alu_b), .alu_func(u3_alu_func), .alu_res(u3_alu_res),
    .alu_zero(u3_alu_zero), .alu_sign(u3_alu_sign), .alu_over(u3_alu_over),
    .busy(u3_busy), .last_grant(u3_last_grant)
  );

  typedef struct {
    logic        sel;
    logic [31:0] res;
    logic [2:0]  flags;
    int          t_acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic drive_req(input logic sel, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
    if (sel) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_func = f;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_func = f;
    end
  endtask

  function automatic logic rdy(input logic sel);
    return sel ? req1_ready : req0_ready;
  endfunction

  // Present one operation on u1, wait for its accept and log the expectation.
  task automatic submit(input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic [31:0] er, input logic [2:0] ef);
    int n;
    exp_t e;
    @(negedge clk);
    drive_req(sel, 1'b1, a, b, f);
    #1;
    n = 0;
    while (rdy(sel) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_in_time", 64'(n < 20), 64'd1);
    e.sel = sel; e.res = er; e.flags = ef; e.t_acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    drive_req(sel, 1'b0, a, b, f);
  endtask

  // Wait for u1's response and compare it against the oldest expectation.
  task automatic collect(input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!(resp0_valid || resp1_valid) && n < 30) begin
      @(negedge clk); n++;
    end
    chk("resp_in_time", 64'(n < 30), 64'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("resp_owner", 64'(resp1_valid), 64'(e.sel));
      chk("resp_onehot", 64'(resp0_valid & resp1_valid), 64'd0);
      chk("resp_res", 64'(e.sel ? resp1_res : resp0_res), 64'(e.res));
      chk("resp_flags", 64'(e.sel ? resp1_flags : resp0_flags), 64'(e.flags));
      chk("resp_latency", 64'(cyc - e.t_acc), 64'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    exp_t e;

    vecs[0] = '{1'b0, 32'd5,          32'd7, 4'd0, 32'd12,         3'b000};
    vecs[1] = '{1'b1, 32'h8000_0000,  32'd1, 4'd1, 32'h7FFF_FFFF,  3'b100};
    vecs[2] = '{1'b0, 32'd3,          32'd3, 4'd1, 32'd0,          3'b001};
    vecs[3] = '{1'b1, 32'd1,          32'd2, 4'd1, 32'hFFFF_FFFF,  3'b010};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF,  32'd1, 4'd0, 32'h8000_0000,  3'b110};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF,  32'd1, 4'd0, 32'd0,          3'b001};
    vecs[6] = '{1'b0, 32'h0000_F0F0,  32'h0000_0FF0, 4'd5, 32'h0000_FF00, 3'b000};

    // reset state, with a request pending that must not be readied
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_outputs", {resp0_valid, resp1_valid, busy, last_grant, alu_func},
        {3'b000, 1'b1, 4'd0});
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_resp_res", {resp0_res, resp1_res}, 64'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // tie after reset: req0 first, then req1 by round robin
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'd5, 32'd7, 4'd0);
    drive_req(1'b1, 1'b1, 32'd10, 32'd4, 4'd1);
    #1;
    chk("tie_ready", {req1_ready, req0_ready}, 64'b01);
    e.sel = 1'b0; e.res = 32'd12; e.flags = 3'b000; e.t_acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("tie_last_grant0", {busy, last_grant}, 64'b10);
    collect(2);
    @(negedge clk); #1;
    chk("tie_rr_ready", {req1_ready, req0_ready}, 64'b10);
    e.sel = 1'b1; e.res = 32'd6; e.flags = 3'b000; e.t_acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("tie_last_grant1", 64'(last_grant), 64'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    collect(2);

    // table-driven single operations
    for (int i = 0; i < 7; i++) begin
      submit(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].func, vecs[i].res, vecs[i].flags);
      collect(2);
    end

    // back-pressure on requester 1
    resp1_ready = 1'b0;
    submit(1'b1, 32'd100, 32'd23, 4'd0, 32'd123, 3'b000);
    collect(2);
    drive_req(1'b0, 1'b1, 32'd9, 32'd9, 4'd0);
    resp0_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_hold", {resp1_valid, busy, req0_ready, resp0_valid, resp1_res},
          {4'b1100, 32'd123});
      @(negedge clk);
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    #1;
    chk("bp_release", {busy, resp1_valid, req0_ready, resp1_res}, {3'b001, 32'd123});
    req0_valid = 1'b0;
    @(negedge clk);
    chk("withdrawn_dropped", 64'(busy), 64'd0);
    resp1_ready = 1'b1;

    // asynchronous reset in the middle of EXEC
    submit(1'b0, 32'd1, 32'd1, 4'd0, 32'd2, 3'b000);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {busy, resp0_valid, resp1_valid, last_grant, alu_func},
        {4'b0001, 4'd0});
    chk("async_rst_data", {alu_a, resp0_res}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) seen++;
    end
    chk("no_resp_after_rst", 64'(seen), 64'd0);

    // ALU_LAT=3 against the lagging ALU (u3 is idle after the reset above)
    submit(1'b0, 32'd20, 32'd22, 4'd0, 32'd42, 3'b000);
    e = sb.pop_front();
    n = 0;
    while (u3_resp0_valid !== 1'b1 && n < 20) begin
      chk("lat3_ops_stable", {u3_alu_a, u3_alu_b[27:0], u3_alu_func},
          {32'd20, 28'd22, 4'd0});
      @(negedge clk);
      n++;
    end
    chk("lat3_in_time", 64'(n < 20), 64'd1);
    chk("lat3_latency", 64'(cyc - e.t_acc), 64'd4);
    chk("lat3_res", {u3_resp0_flags, u3_resp0_res}, {3'b000, e.res});
    chk("lat3_onehot", 64'(u3_resp1_valid), 64'd0);
    @(negedge clk);
    chk("lat3_after_hs", {u3_busy, u3_resp0_valid, u3_alu_a, u3_alu_b[27:0], u3_alu_func},
        {2'b00, 32'd20, 28'd22, 4'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
